// File: rtl/id_ex_stage_buf.sv
// ID/EX elastic pipeline stage: a main entry M feeding execute plus a skid entry S,
// so that in_ready is a registered signal. Also provides a synchronous flush and a saturating stall counter.
module id_ex_stage_buf #(
  parameter int DATA_W   = 32,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALUOP_W-1:0]  aluop_in,
  input  logic [ALUSEL_W-1:0] alusel_in,
  input  logic [DATA_W-1:0]   op1_in,
  input  logic [DATA_W-1:0]   op2_in,
  input  logic [ADDR_W-1:0]   dest_in,
  input  logic                wreg_in,
  input  logic [DATA_W-1:0]   pc_in,
  input  logic                dslot_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALUOP_W-1:0]  aluop_out,
  output logic [ALUSEL_W-1:0] alusel_out,
  output logic [DATA_W-1:0]   op1_out,
  output logic [DATA_W-1:0]   op2_out,
  output logic [ADDR_W-1:0]   dest_out,
  output logic                wreg_out,
  output logic [DATA_W-1:0]   pc_out,
  output logic                dslot_out,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int PW = ALUOP_W + ALUSEL_W + 3 * DATA_W + ADDR_W + 2;

  logic [PW-1:0]    in_bundle;
  logic [PW-1:0]    m_data_reg, m_data_next;
  logic [PW-1:0]    s_data_reg, s_data_next;
  logic             m_valid_reg, m_valid_next;
  logic             s_valid_reg, s_valid_next;
  logic             in_ready_reg, in_ready_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             accept, drain;

  assign in_bundle = {aluop_in, alusel_in, op1_in, op2_in, dest_in, wreg_in, pc_in, dslot_in};
  assign {aluop_out, alusel_out, op1_out, op2_out, dest_out, wreg_out, pc_out, dslot_out} = m_data_reg;

  assign in_ready  = in_ready_reg;
  assign out_valid = m_valid_reg;
  assign stall_cnt = cnt_reg;

  assign accept = in_valid && in_ready_reg;
  assign drain  = m_valid_reg && out_ready;

  always_comb begin
    m_valid_next = m_valid_reg;
    m_data_next  = m_data_reg;
    s_valid_next = s_valid_reg;
    s_data_next  = s_data_reg;
    if (flush) begin
      m_valid_next = 1'b0;
      m_data_next  = '0;
      s_valid_next = 1'b0;
      s_data_next  = '0;
    end else if (!m_valid_reg || drain) begin
      if (s_valid_reg) begin
        m_valid_next = 1'b1;
        m_data_next  = s_data_reg;
        s_valid_next = accept;
        s_data_next  = accept ? in_bundle : '0;
      end else if (accept) begin
        m_valid_next = 1'b1;
        m_data_next  = in_bundle;
      end else begin
        // Empty M always shows an all-zero payload, so wreg_out reads as a NOP.
        m_valid_next = 1'b0;
        m_data_next  = '0;
      end
    end else if (accept) begin
      s_valid_next = 1'b1;
      s_data_next  = in_bundle;
    end
  end

  assign in_ready_next = !s_valid_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (m_valid_reg && !out_ready && (cnt_reg != {CNT_W{1'b1}}))
      cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_reg  <= 1'b0;
      m_data_reg   <= '0;
      s_valid_reg  <= 1'b0;
      s_data_reg   <= '0;
      in_ready_reg <= 1'b1;
      cnt_reg      <= '0;
    end else begin
      m_valid_reg  <= m_valid_next;
      m_data_reg   <= m_data_next;
      s_valid_reg  <= s_valid_next;
      s_data_reg   <= s_data_next;
      in_ready_reg <= in_ready_next;
      cnt_reg      <= cnt_next;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_buf.sv
// Scoreboard bench for id_ex_stage_buf: accepted beats are queued, and a monitor checks each drained beat in order.
module tb_id_ex_stage_buf;

  localparam int PW = 8 + 3 + 3 * 32 + 5 + 2;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  aluop_in, aluop_out;
  logic [2:0]  alusel_in, alusel_out;
  logic [31:0] op1_in, op2_in, pc_in, op1_out, op2_out, pc_out;
  logic [4:0]  dest_in, dest_out;
  logic        wreg_in, wreg_out, dslot_in, dslot_out;
  logic [15:0] stall_cnt;

  logic        sat_in_valid, sat_in_ready, sat_out_valid, sat_wreg, sat_dslot;
  logic [7:0]  sat_aluop;
  logic [2:0]  sat_alusel;
  logic [31:0] sat_op1, sat_op2, sat_pc;
  logic [4:0]  sat_dest;
  logic [3:0]  sat_cnt;

  int errors = 0;
  int checks = 0;
  logic [PW-1:0] exp_q[$];

  always #5 clk = ~clk;

  id_ex_stage_buf dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .aluop_in(aluop_in), .alusel_in(alusel_in), .op1_in(op1_in), .op2_in(op2_in),
    .dest_in(dest_in), .wreg_in(wreg_in), .pc_in(pc_in), .dslot_in(dslot_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluop_out(aluop_out), .alusel_out(alusel_out), .op1_out(op1_out), .op2_out(op2_out),
    .dest_out(dest_out), .wreg_out(wreg_out), .pc_out(pc_out), .dslot_out(dslot_out),
    .stall_cnt(stall_cnt)
  );

  id_ex_stage_buf #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(sat_in_valid), .in_ready(sat_in_ready),
    .aluop_in(8'h11), .alusel_in(3'd1), .op1_in(32'h1), .op2_in(32'h2),
    .dest_in(5'd1), .wreg_in(1'b1), .pc_in(32'h40), .dslot_in(1'b0),
    .out_valid(sat_out_valid), .out_ready(1'b0),
    .aluop_out(sat_aluop), .alusel_out(sat_alusel), .op1_out(sat_op1), .op2_out(sat_op2),
    .dest_out(sat_dest), .wreg_out(sat_wreg), .pc_out(sat_pc), .dslot_out(sat_dslot),
    .stall_cnt(sat_cnt)
  );

  wire [PW-1:0] in_bus  = {aluop_in, alusel_in, op1_in, op2_in, dest_in, wreg_in, pc_in, dslot_in};
  wire [PW-1:0] out_bus = {aluop_out, alusel_out, op1_out, op2_out, dest_out, wreg_out, pc_out, dslot_out};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Acceptance is recorded at the clock edge where the transfer happens.
  always @(posedge clk)
    if (!rst && !flush && in_valid && in_ready)
      exp_q.push_back(in_bus);

  // Monitor: compares drained beats in order and checks that bubbles carry a zero payload.
  always @(negedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
    end else if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL drain_order: got beat 0x%0h with nothing expected", out_bus);
      end else begin
        logic [PW-1:0] e;
        e = exp_q.pop_front();
        if (out_bus !== e) begin
          errors++;
          $display("FAIL drain_order: got 0x%0h expected 0x%0h", out_bus, e);
        end
      end
    end else if (!out_valid) begin
      chk("bubble_zero", 64'(out_bus == '0), 64'd1);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] op1, input logic [4:0] dest, input logic [31:0] pc);
    in_valid  = 1'b1;
    aluop_in  = op1[7:0] ^ 8'h5A;
    alusel_in = 3'd3;
    op1_in    = op1;
    op2_in    = ~op1;
    dest_in   = dest;
    wreg_in   = 1'b1;
    pc_in     = pc;
    dslot_in  = pc[2];
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; sat_in_valid = 1'b0;
    beat(32'hDEADBEEF, 5'd9, 32'h80);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_op1_out", 64'(op1_out), 64'd0);
    chk("rst_wreg_out", 64'(wreg_out), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    rst = 1'b0;
    in_valid = 1'b0;

    // Streaming: four beats back to back with out_ready high.
    next_cycle();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      beat(32'(i), 5'(4 + i), 32'h200 + 32'(4 * i));
      @(negedge clk);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      if (i > 1) chk("stream_op1_out", 64'(op1_out), 64'(i - 1));
      next_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", 64'(out_valid), 64'd1);
    chk("stream_last_op1", 64'(op1_out), 64'd4);
    next_cycle();
    @(negedge clk);
    chk("stream_bubble_valid", 64'(out_valid), 64'd0);

    // Backpressure: A and B fill M and S, while C waits.
    next_cycle();
    out_ready = 1'b0;
    beat(32'hA, 5'd1, 32'h100);
    @(negedge clk);
    chk("bp_a_in_ready", 64'(in_ready), 64'd1);
    next_cycle();
    beat(32'hB, 5'd2, 32'h104);
    @(negedge clk);
    chk("bp_pc_a", 64'(pc_out), 64'h100);
    chk("bp_stall0", 64'(stall_cnt), 64'd0);
    next_cycle();
    beat(32'hC, 5'd3, 32'h108);
    @(negedge clk);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_stall1", 64'(stall_cnt), 64'd1);
    next_cycle();
    @(negedge clk);
    chk("bp_stall2", 64'(stall_cnt), 64'd2);
    next_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_stall3", 64'(stall_cnt), 64'd3);
    chk("bp_pc_a_drain", 64'(pc_out), 64'h100);
    next_cycle();
    @(negedge clk);
    chk("bp_pc_b", 64'(pc_out), 64'h104);
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_pc_c", 64'(pc_out), 64'h108);
    chk("bp_stall_hold", 64'(stall_cnt), 64'd3);
    next_cycle();

    // Flush with M and S full and a new input presented.
    out_ready = 1'b0;
    beat(32'hD, 5'd4, 32'h300);
    next_cycle();
    beat(32'hE, 5'd5, 32'h304);
    next_cycle();
    beat(32'hF, 5'd6, 32'h308);
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_wreg_out", 64'(wreg_out), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    chk("fl_stall_kept", 64'(stall_cnt), 64'd5);

    // Flush while in_ready=1: the presented input is still discarded.
    next_cycle();
    beat(32'h10, 5'd7, 32'h400);
    next_cycle();
    beat(32'h11, 5'd8, 32'h404);
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl2_out_valid", 64'(out_valid), 64'd0);
    chk("fl2_in_ready", 64'(in_ready), 64'd1);
    chk("fl2_stall", 64'(stall_cnt), 64'd6);
    out_ready = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("fl2_nothing_out", 64'(out_valid), 64'd0);

    // Random traffic with sporadic flushes, checked by the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      beat($urandom, 5'($urandom), $urandom);
      in_valid  = ($urandom_range(0, 9) < 6);
      wreg_in   = 1'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 2);
    end
    next_cycle();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) next_cycle();
    @(negedge clk);
    chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("rand_out_idle", 64'(out_valid), 64'd0);

    // Saturation on a 4-bit counter held stalled for 20 cycles.
    next_cycle();
    sat_in_valid = 1'b1;
    next_cycle();
    sat_in_valid = 1'b0;
    repeat (10) next_cycle();
    @(negedge clk);
    chk("sat_mid", 64'(sat_cnt), 64'd10);
    repeat (10) next_cycle();
    @(negedge clk);
    chk("sat_stop15", 64'(sat_cnt), 64'd15);
    chk("sat_in_ready", 64'(sat_in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
